// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined Booth multiplier: Booth digit codes,
// partial-product count and the carry-save adder cell.
package mul_pkg;

    typedef logic [2:0] booth_code_t;

    localparam booth_code_t BOOTH_ZERO = 3'd0;
    localparam booth_code_t BOOTH_P1   = 3'd1;
    localparam booth_code_t BOOTH_P2   = 3'd2;
    localparam booth_code_t BOOTH_M1   = 3'd3;
    localparam booth_code_t BOOTH_M2   = 3'd4;

    // One extra group covers the zero/sign extension bits of the multiplier
    function automatic int calc_npp(input int width);
        return (width / 2) + 1;
    endfunction

    // Radix-4 Booth digit for {b[2i+1], b[2i], b[2i-1]}; neg flips the sign of the digit
    function automatic booth_code_t booth_decode(input logic [2:0] grp, input logic neg);
        booth_code_t code;
        case (grp)
            3'b000, 3'b111: code = BOOTH_ZERO;
            3'b001, 3'b010: code = neg ? BOOTH_M1 : BOOTH_P1;
            3'b011:         code = neg ? BOOTH_M2 : BOOTH_P2;
            3'b100:         code = neg ? BOOTH_P2 : BOOTH_M2;
            3'b101, 3'b110: code = neg ? BOOTH_P1 : BOOTH_M1;
            default:        code = BOOTH_ZERO;
        endcase
        return code;
    endfunction

    // 3:2 carry-save cell, returns {carry, sum}
    function automatic logic [1:0] csa_bit(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product: selects 0/+-A/+-2A from the extended
// multiplicand and places it at bit offset 2*IDX within a 2*WIDTH row.
module booth_pp_gen
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX   = 0
) (
    input  logic [WIDTH+1:0]   a_ext,
    input  logic [2:0]         grp,
    input  logic               neg,
    output logic [2*WIDTH-1:0] pp
);

    booth_code_t        code_s;
    logic [2*WIDTH-1:0] a_sx_s;
    logic [2*WIDTH-1:0] a_x2_s;
    logic [2*WIDTH-1:0] mag_s;

    assign code_s = booth_decode(grp, neg);
    assign a_sx_s = {{(WIDTH-2){a_ext[WIDTH+1]}}, a_ext};
    assign a_x2_s = {a_sx_s[2*WIDTH-2:0], 1'b0};

    // Digit selection in two's complement, modulo 2^(2*WIDTH)
    always_comb begin
        mag_s = '0;
        case (code_s)
            BOOTH_P1: mag_s = a_sx_s;
            BOOTH_P2: mag_s = a_x2_s;
            BOOTH_M1: mag_s = {(2*WIDTH){1'b0}} - a_sx_s;
            BOOTH_M2: mag_s = {(2*WIDTH){1'b0}} - a_x2_s;
            default:  mag_s = '0;
        endcase
    end

    assign pp = mag_s << (2 * IDX);

endmodule

// File: rtl/booth_mul_pipe.sv
// 3-stage radix-4 Booth / Wallace multiplier with valid/ready and flush.
// Optional multiply-accumulate/subtract enabled by macro BOOTH_MUL_ACC_EN.
module booth_mul_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
`ifdef BOOTH_MUL_ACC_EN
    input  logic               acc_en,
    input  logic               acc_sub,
    input  logic [2*WIDTH-1:0] acc_in,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_res
);

    localparam int NPP  = calc_npp(WIDTH);
`ifdef BOOTH_MUL_ACC_EN
    localparam int ROWS = NPP + 1;
`else
    localparam int ROWS = NPP;
`endif
    localparam int NCSA = ROWS - 2;
    localparam int POOL = ROWS + 2 * NCSA;

    logic               stall_s;
    logic               accept_s;
    logic               neg_s;
    logic [WIDTH+1:0]   a_ext_s;
    logic [WIDTH+2:0]   b_pad_s;
    logic [2*WIDTH-1:0] pp_s [NPP];
    logic [2*WIDTH-1:0] pp_r [NPP];
    logic [2*WIDTH-1:0] pool_s [POOL];
    logic [1:0]         fa_s;
    logic [2*WIDTH-1:0] tree_sum_s;
    logic [2*WIDTH-1:0] tree_carry_s;
    logic [2*WIDTH-1:0] sum_r;
    logic [2*WIDTH-1:0] carry_r;
    logic               s1_valid_r;
    logic               s2_valid_r;

    assign stall_s  = out_valid & ~out_ready;
    assign in_ready = ~stall_s;
    assign accept_s = in_valid & in_ready;

    assign a_ext_s = {{2{in_signed & in_a[WIDTH-1]}}, in_a};
    assign b_pad_s = {{2{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};

`ifdef BOOTH_MUL_ACC_EN
    logic [2*WIDTH-1:0] acc_row_s;
    logic [2*WIDTH-1:0] acc_row_r;

    // Negating every partial product turns acc + a*b into acc - a*b
    assign neg_s     = acc_en & acc_sub;
    assign acc_row_s = acc_en ? acc_in : {(2*WIDTH){1'b0}};
`else
    assign neg_s = 1'b0;
`endif

    for (genvar i = 0; i < NPP; i++) begin : g_pp
        booth_pp_gen #(
            .WIDTH (WIDTH),
            .IDX   (i)
        ) u_pp (
            .a_ext (a_ext_s),
            .grp   (b_pad_s[2*i+2 -: 3]),
            .neg   (neg_s),
            .pp    (pp_s[i])
        );
    end

    // Carry-save tree: rows are consumed oldest-first so the CSAs levelise like a Wallace tree
    always_comb begin
        fa_s = 2'b00;
        for (int r = 0; r < POOL; r++) begin
            pool_s[r] = '0;
        end
        for (int r = 0; r < NPP; r++) begin
            pool_s[r] = pp_r[r];
        end
`ifdef BOOTH_MUL_ACC_EN
        pool_s[NPP] = acc_row_r;
`endif
        for (int k = 0; k < NCSA; k++) begin
            for (int j = 0; j < 2*WIDTH; j++) begin
                fa_s = csa_bit(pool_s[3*k][j], pool_s[3*k+1][j], pool_s[3*k+2][j]);
                pool_s[ROWS+2*k][j] = fa_s[0];
                if (j < 2*WIDTH-1) begin
                    pool_s[ROWS+2*k+1][j+1] = fa_s[1];
                end else begin
                    pool_s[ROWS+2*k+1][0] = 1'b0;
                end
            end
        end
        tree_sum_s   = pool_s[POOL-2];
        tree_carry_s = pool_s[POOL-1];
    end

    // Stage data registers; bubbles may carry don't-care data
    always_ff @(posedge clk) begin
        if (!stall_s) begin
            for (int i = 0; i < NPP; i++) begin
                pp_r[i] <= pp_s[i];
            end
`ifdef BOOTH_MUL_ACC_EN
            acc_row_r <= acc_row_s;
`endif
            sum_r   <= tree_sum_s;
            carry_r <= tree_carry_s;
        end
    end

    // Stage valids and result register; flush outranks stall
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            out_valid  <= 1'b0;
            out_res    <= '0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            out_valid  <= 1'b0;
        end else if (!stall_s) begin
            s1_valid_r <= accept_s;
            s2_valid_r <= s1_valid_r;
            out_valid  <= s2_valid_r;
            if (s2_valid_r) begin
                out_res <= sum_r + carry_r;
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_pipe.sv
// Scoreboard bench for booth_mul_pipe (32-bit and 8-bit instances); the
// accumulate checks are included when BOOTH_MUL_ACC_EN is defined.
module tb_booth_mul_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_signed, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b;
    logic [63:0] out_res;
    logic        in_valid8, in_signed8, in_ready8, out_valid8;
    logic        out_ready8 = 1'b1;
    logic [7:0]  in_a8, in_b8;
    logic [15:0] out_res8;
`ifdef BOOTH_MUL_ACC_EN
    logic        acc_en = 1'b0, acc_sub = 1'b0;
    logic [63:0] acc_in = 64'd0;
    logic        acc_en8 = 1'b0, acc_sub8 = 1'b0;
    logic [15:0] acc_in8 = 16'd0;
`endif

    logic [63:0] exp_q [$];
    logic [15:0] exp8_q [$];
    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int valid_cnt = 0;
    int run_len = 0;
    int max_run = 0;

    always #5 clk = ~clk;

    booth_mul_pipe #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .in_a(in_a), .in_b(in_b),
`ifdef BOOTH_MUL_ACC_EN
        .acc_en(acc_en), .acc_sub(acc_sub), .acc_in(acc_in),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res)
    );

    booth_mul_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_signed(in_signed8), .in_a(in_a8), .in_b(in_b8),
`ifdef BOOTH_MUL_ACC_EN
        .acc_en(acc_en8), .acc_sub(acc_sub8), .acc_in(acc_in8),
`endif
        .out_valid(out_valid8), .out_ready(out_ready8), .out_res(out_res8)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: extend each operand to full product width and multiply
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn, input logic [63:0] acc,
                                            input logic sub);
        logic [63:0] ea, eb, prod;
        ea   = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        eb   = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        prod = ea * eb;
        return sub ? (acc - prod) : (acc + prod);
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic sgn);
        logic [15:0] ea, eb;
        ea = sgn ? {{8{a[7]}}, a} : {8'd0, a};
        eb = sgn ? {{8{b[7]}}, b} : {8'd0, b};
        return ea * eb;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] exp);
        int guard = 0;
        in_a = a; in_b = b; in_signed = sgn; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready) exp_q.push_back(exp);
        else check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                          input logic [15:0] exp);
        int guard = 0;
        in_a8 = a; in_b8 = b; in_signed8 = sgn; in_valid8 = 1'b1;
        @(negedge clk);
        while (!in_ready8 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready8) exp8_q.push_back(exp);
        else check("accept8_timeout", 64'(in_ready8), 64'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || exp8_q.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_empty", 64'(exp_q.size() + exp8_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Consumer readiness: 0 = always ready, 1 = blocked, 2 = random
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks held data while stalled
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid) begin
                    valid_cnt++;
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                end else begin
                    run_len = 0;
                end
                if (out_valid && exp_q.size() == 0)
                    check("unexpected_out", 64'(out_valid), 64'd0);
                else if (out_valid && out_ready)
                    check("result", out_res, exp_q.pop_front());
                else if (out_valid)
                    check("stall_hold", out_res, exp_q[0]);
                if (out_valid8 && exp8_q.size() == 0)
                    check("unexpected_out8", 64'(out_valid8), 64'd0);
                else if (out_valid8)
                    check("result8", 64'(out_res8), 64'(exp8_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        int          lat, base;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0;
        in_valid8 = 1'b0; in_signed8 = 1'b0; in_a8 = '0; in_b8 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_res", out_res, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Single signed op: latency and one-cycle pulse
        max_run = 0;
        issue(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check("latency", 64'(lat), 64'd3);
        drain();
        check("single_pulse", 64'(max_run), 64'd1);

        // Boundaries
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
        issue(32'h0000_0000, 32'h1234_5678, 1'b1, 64'd0);
        issue(32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 64'd0);
        drain();

        // Back-to-back
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            issue(a, b, s, ref_mul(a, b, s, 64'd0, 1'b0));
        end
        drain();
        check("b2b_run", 64'(max_run), 64'd8);

        // Backpressure with the pipe full
        ready_mode = 1;
        @(posedge clk); #3;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            issue(a, b, s, ref_mul(a, b, s, 64'd0, 1'b0));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        ready_mode = 0;
        drain();

        // Flush after two accepts with a third input offered
        for (int i = 0; i < 2; i++) begin
            a = $urandom; b = $urandom;
            issue(a, b, 1'b1, ref_mul(a, b, 1'b1, 64'd0, 1'b0));
        end
        exp_q.delete();
        flush = 1'b1; in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        base = valid_cnt;
        repeat (6) @(negedge clk);
        check("flush_no_valid", 64'(valid_cnt - base), 64'd0);
        @(posedge clk); #1;
        a = $urandom; b = $urandom;
        issue(a, b, 1'b0, ref_mul(a, b, 1'b0, 64'd0, 1'b0));
        drain();

        // Reset mid-operation
        a = $urandom; b = $urandom;
        issue(a, b, 1'b1, ref_mul(a, b, 1'b1, 64'd0, 1'b0));
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        base = valid_cnt;
        repeat (5) @(negedge clk);
        check("rst_mid_no_valid", 64'(valid_cnt - base), 64'd0);
        check("rst_mid_out_res", out_res, 64'd0);
        @(posedge clk); #1;

        // Random traffic with random backpressure
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            issue(a, b, s, ref_mul(a, b, s, 64'd0, 1'b0));
        end
        ready_mode = 0;
        drain();

`ifdef BOOTH_MUL_ACC_EN
        acc_en = 1'b1; acc_sub = 1'b1; acc_in = 64'd10;
        issue(32'd3, 32'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            acc_sub = 1'($urandom_range(0, 1)); acc_in = {$urandom, $urandom};
            issue(a, b, s, ref_mul(a, b, s, acc_in, acc_sub));
        end
        acc_en = 1'b0; acc_sub = 1'b0;
        drain();
`endif

        // 8-bit instance
        issue8(8'h80, 8'h80, 1'b1, 16'h4000);
        issue8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        for (int i = 0; i < 12; i++) begin
            logic [7:0] a8, b8;
            a8 = 8'($urandom); b8 = 8'($urandom); s = 1'($urandom_range(0, 1));
            issue8(a8, b8, s, ref8(a8, b8, s));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
